// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the round-robin
// arbiter that drives the datapath's 4:1 select multiplexer.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first request at or after ptr_i,
// ignoring requesters masked out by excl_i.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic [N_REQ-1:0] excl_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o,
    output logic [N_REQ-1:0] onehot_o
);

    logic [N_REQ-1:0] cand;
    logic [SEL_W-1:0] pos;

    assign cand = req_i & ~excl_i;

    // Scan from the farthest slot back to ptr so the nearest candidate wins.
    always_comb begin
        onehot_o = '0;
        pos      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = ptr_i + SEL_W'(k);
            if (cand[pos]) begin
                onehot_o      = '0;
                onehot_o[pos] = 1'b1;
            end
        end
    end

    assign found_o = |onehot_o;
    assign idx_o   = onehot_to_idx(onehot_o);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for the shared 4:1 select mux, with zero-bubble
// handover on release and optional forced rotation after MAX_HOLD cycles.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             preempt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic             PREEMPT_ON = (MAX_HOLD > 0);

    state_t           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;
    logic [CNT_W-1:0] hold_q;
    logic             busy_q;
    logic             preempt_q;

    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_excl;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             owner_req;
    logic             hold_full;

    // While granted, the picker looks past the owner; when idle it scans from ptr.
    assign ptr_d     = sel_q + SEL_W'(1);
    assign pick_ptr  = (state_q == GRANT) ? ptr_d : ptr_q;
    assign pick_excl = (state_q == GRANT) ? gnt_q : '0;
    assign owner_req = |(req & gnt_q);
    assign hold_full = (hold_q == HOLD_LAST);

    rr_pick u_pick (
        .req_i    (req),
        .ptr_i    (pick_ptr),
        .excl_i   (pick_excl),
        .found_o  (pick_found),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && pick_found) begin
                        gnt_q   <= pick_onehot;
                        sel_q   <= pick_idx;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        ptr_q <= ptr_d;
                        if (en && pick_found) begin
                            gnt_q  <= pick_onehot;
                            sel_q  <= pick_idx;
                            hold_q <= '0;
                        end else begin
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (PREEMPT_ON && hold_full && en && pick_found) begin
                        ptr_q     <= ptr_d;
                        gnt_q     <= pick_onehot;
                        sel_q     <= pick_idx;
                        hold_q    <= '0;
                        preempt_q <= 1'b1;
                    end else if (!hold_full) begin
                        hold_q <= hold_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule
